qnna_mac_tile: RTL and testbench

Parametrised INT8 outer-product MAC tile: the second-generation QNNA compute engine. It computes a ROWS x COLS output block C = A·B over a programmable K depth by streaming one A column and one B row per beat, then drains requantised, optionally ReLU'd INT8 rows through a valid/ready port. It sits between the operand buffers (upstream stream) and the output writeback buffer (downstream stream), under control of the QNNA command sequencer (start/done).

---
 rtl/qnna_mac_tile_if.sv | 28 ++
 rtl/qnna_mac_tile.sv | 189 ++++++++++++++++++
 tb/tb_qnna_mac_tile.sv | 349 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/qnna_mac_tile_if.sv
// Operand-beat and result-row streams of the QNNA MAC tile.
// master drives operand beats and takes result rows; slave is the tile itself.
interface qnna_mac_tile_if #(
    parameter int ROWS   = 4,
    parameter int COLS   = 4,
    parameter int DATA_W = 8
);
    localparam int IDX_W = (ROWS > 1) ? $clog2(ROWS) : 1;

    logic                     in_valid;
    logic                     in_ready;
    logic [ROWS*DATA_W-1:0]   in_a;
    logic [COLS*DATA_W-1:0]   in_b;
    logic                     out_valid;
    logic                     out_ready;
    logic [IDX_W-1:0]         out_row_idx;
    logic [COLS*DATA_W-1:0]   out_data;

    modport master (
        output in_valid, in_a, in_b, out_ready,
        input  in_ready, out_valid, out_row_idx, out_data
    );

    modport slave (
        input  in_valid, in_a, in_b, out_ready,
        output in_ready, out_valid, out_row_idx, out_data
    );
endinterface

// File: rtl/qnna_mac_tile.sv
// INT8 outer-product MAC tile: accumulates ROWS x COLS over dim_k beats, then drains
// requantised (shift, optional ReLU, saturate) rows one per handshake.
//   state  | meaning
//   IDLE   | waiting for start
//   ACCUM  | consuming operand beats, one per cycle
//   DRAIN  | presenting result rows 0..ROWS-1
//   DONE   | one-cycle completion pulse
module qnna_mac_tile #(
    parameter int ROWS    = 4,
    parameter int COLS    = 4,
    parameter int DATA_W  = 8,
    parameter int ACC_W   = 32,
    parameter int SHIFT_W = 5
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start_i,
    input  logic [15:0]        dim_k_i,
    input  logic               relu_en_i,
    input  logic [SHIFT_W-1:0] shift_i,
    output logic               busy_o,
    output logic               done_o,
    qnna_mac_tile_if.slave     strm_io
);
    localparam int IDX_W = (ROWS > 1) ? $clog2(ROWS) : 1;
    localparam logic signed [ACC_W-1:0] SAT_MAX = ACC_W'((1 <<< (DATA_W - 1)) - 1);
    localparam logic signed [ACC_W-1:0] SAT_MIN = ACC_W'(-(1 <<< (DATA_W - 1)));

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ACCUM = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t                  state_q, state_d;
    logic [15:0]             dim_k_q, dim_k_d;
    logic [15:0]             k_q, k_d;
    logic                    relu_q, relu_d;
    logic [SHIFT_W-1:0]      shift_q, shift_d;
    logic [IDX_W-1:0]        row_q, row_d;
    logic signed [ACC_W-1:0] acc_q [ROWS][COLS];
    logic signed [ACC_W-1:0] acc_d [ROWS][COLS];

    logic cmd_acc;
    logic beat;
    logic last_beat;
    logic out_hs;
    logic last_row;

    // Full-precision product, then sign-extended or wrapped to the accumulator width.
    function automatic logic signed [ACC_W-1:0] mul_ext(
        input logic signed [DATA_W-1:0] a,
        input logic signed [DATA_W-1:0] b
    );
        logic signed [2*DATA_W-1:0] p;
        p = (2*DATA_W)'(a) * (2*DATA_W)'(b);
        return ACC_W'(p);
    endfunction

    function automatic logic [DATA_W-1:0] requant(
        input logic signed [ACC_W-1:0] acc,
        input logic [SHIFT_W-1:0]      sh,
        input logic                    relu
    );
        logic signed [ACC_W-1:0] v;
        v = acc >>> sh;
        if (relu && v[ACC_W-1]) begin
            v = '0;
        end
        if (v > SAT_MAX) begin
            v = SAT_MAX;
        end else if (v < SAT_MIN) begin
            v = SAT_MIN;
        end
        return v[DATA_W-1:0];
    endfunction

    assign cmd_acc   = (state_q == S_IDLE) && start_i;
    assign beat      = (state_q == S_ACCUM) && strm_io.in_valid;
    assign last_beat = beat && ((k_q + 16'd1) == dim_k_q);
    assign out_hs    = (state_q == S_DRAIN) && strm_io.out_ready;
    assign last_row  = (row_q == IDX_W'(ROWS - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    state_d = (dim_k_i == 16'd0) ? S_DRAIN : S_ACCUM;
                end
            end
            S_ACCUM: begin
                if (last_beat) begin
                    state_d = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (out_hs && last_row) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_comb begin
        busy_o              = (state_q != S_IDLE);
        done_o              = (state_q == S_DONE);
        strm_io.in_ready    = (state_q == S_ACCUM);
        strm_io.out_valid   = (state_q == S_DRAIN);
        strm_io.out_row_idx = row_q;
        strm_io.out_data    = '0;
        if (state_q == S_DRAIN) begin
            for (int c = 0; c < COLS; c++) begin
                strm_io.out_data[c*DATA_W +: DATA_W] = requant(acc_q[row_q][c], shift_q, relu_q);
            end
        end
    end

    always_comb begin
        dim_k_d = dim_k_q;
        relu_d  = relu_q;
        shift_d = shift_q;
        k_d     = k_q;
        row_d   = row_q;
        acc_d   = acc_q;
        if (cmd_acc) begin
            dim_k_d = dim_k_i;
            relu_d  = relu_en_i;
            shift_d = shift_i;
            k_d     = '0;
            row_d   = '0;
            for (int r = 0; r < ROWS; r++) begin
                for (int c = 0; c < COLS; c++) begin
                    acc_d[r][c] = '0;
                end
            end
        end
        if (beat) begin
            k_d = k_q + 16'd1;
            for (int r = 0; r < ROWS; r++) begin
                for (int c = 0; c < COLS; c++) begin
                    acc_d[r][c] = acc_q[r][c] + mul_ext(strm_io.in_a[r*DATA_W +: DATA_W],
                                                        strm_io.in_b[c*DATA_W +: DATA_W]);
                end
            end
        end
        // Row index wraps to 0 after the last row so the next command starts clean.
        if (out_hs) begin
            row_d = last_row ? '0 : row_q + IDX_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            dim_k_q <= '0;
            relu_q  <= 1'b0;
            shift_q <= '0;
            k_q     <= '0;
            row_q   <= '0;
            for (int r = 0; r < ROWS; r++) begin
                for (int c = 0; c < COLS; c++) begin
                    acc_q[r][c] <= '0;
                end
            end
        end else begin
            dim_k_q <= dim_k_d;
            relu_q  <= relu_d;
            shift_q <= shift_d;
            k_q     <= k_d;
            row_q   <= row_d;
            acc_q   <= acc_d;
        end
    end
endmodule

// File: tb/tb_qnna_mac_tile.sv
// Scoreboard bench for qnna_mac_tile: directed commands push expected rows, monitors pop on handshake.
// A second ACC_W=16 instance runs in lockstep for the accumulator wrap case.
module tb_qnna_mac_tile;
    localparam int ROWS    = 4;
    localparam int COLS    = 4;
    localparam int DATA_W  = 8;
    localparam int SHIFT_W = 5;
    localparam int MAXK    = 8;

    typedef struct packed {
        logic [1:0]  idx;
        logic [31:0] data;
    } exp_t;

    logic               clk = 1'b0;
    logic               rst;
    logic               start;
    logic               relu_en;
    logic [15:0]        dim_k;
    logic [SHIFT_W-1:0] shift;
    logic               busy0, done0, busy1, done1;

    qnna_mac_tile_if #(.ROWS(ROWS), .COLS(COLS), .DATA_W(DATA_W)) s0 ();
    qnna_mac_tile_if #(.ROWS(ROWS), .COLS(COLS), .DATA_W(DATA_W)) s1 ();

    assign s1.in_valid  = s0.in_valid;
    assign s1.in_a      = s0.in_a;
    assign s1.in_b      = s0.in_b;
    assign s1.out_ready = s0.out_ready;

    qnna_mac_tile #(.ROWS(ROWS), .COLS(COLS), .DATA_W(DATA_W), .ACC_W(32), .SHIFT_W(SHIFT_W)) dut (
        .clk(clk), .rst(rst), .start_i(start), .dim_k_i(dim_k), .relu_en_i(relu_en),
        .shift_i(shift), .busy_o(busy0), .done_o(done0), .strm_io(s0)
    );

    qnna_mac_tile #(.ROWS(ROWS), .COLS(COLS), .DATA_W(DATA_W), .ACC_W(16), .SHIFT_W(SHIFT_W)) dut16 (
        .clk(clk), .rst(rst), .start_i(start), .dim_k_i(dim_k), .relu_en_i(relu_en),
        .shift_i(shift), .busy_o(busy1), .done_o(done1), .strm_io(s1)
    );

    always #5 clk = ~clk;

    int          n_checks = 0;
    int          n_pass   = 0;
    int          cyc      = 0;
    int          done_cnt = 0;
    int          done_cyc = 0;
    int          start_cyc = 0;
    bit          en16 = 1'b0;
    bit          stall = 1'b0;
    logic [1:0]  st_idx;
    logic [31:0] st_data;
    exp_t        e0, e1;
    exp_t        q0[$];
    exp_t        q1[$];
    int          a_mem [MAXK][ROWS];
    int          b_mem [MAXK][COLS];
    logic [31:0] rq_exp  [3];
    bit          rq_relu [3];
    int          rq_sh   [3];

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
        $fatal(1);
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    always @(negedge clk) begin
        if (rst) begin
            stall = 1'b0;
        end else begin
            if (stall) begin
                check("stall_valid", 64'(s0.out_valid), 64'(1));
                check("stall_idx", 64'(s0.out_row_idx), 64'(st_idx));
                check("stall_data", 64'(s0.out_data), 64'(st_data));
            end
            if (s0.out_valid && s0.out_ready) begin
                if (q0.size() == 0) begin
                    n_checks++;
                    $display("FAIL unexpected_row: row %0d data %h with nothing expected", s0.out_row_idx, s0.out_data);
                end else begin
                    e0 = q0.pop_front();
                    check("row_idx", 64'(s0.out_row_idx), 64'(e0.idx));
                    check("row_data", 64'(s0.out_data), 64'(e0.data));
                end
            end
            stall   = s0.out_valid && !s0.out_ready;
            st_idx  = s0.out_row_idx;
            st_data = s0.out_data;
            if (done0) begin
                done_cnt++;
                done_cyc = cyc;
            end
        end
    end

    always @(negedge clk) begin
        if (!rst && en16 && s1.out_valid && s1.out_ready) begin
            if (q1.size() == 0) begin
                n_checks++;
                $display("FAIL unexpected_row16: row %0d data %h with nothing expected", s1.out_row_idx, s1.out_data);
            end else begin
                e1 = q1.pop_front();
                check("acc16_idx", 64'(s1.out_row_idx), 64'(e1.idx));
                check("acc16_data", 64'(s1.out_data), 64'(e1.data));
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push0(input int r, input logic [31:0] d);
        exp_t e;
        e.idx  = 2'(r);
        e.data = d;
        q0.push_back(e);
    endtask

    task automatic push1(input int r, input logic [31:0] d);
        exp_t e;
        e.idx  = 2'(r);
        e.data = d;
        q1.push_back(e);
    endtask

    function automatic logic [31:0] model_row(input int r, input int k, input bit relu, input int sh);
        logic [31:0] d;
        longint      acc;
        int          v;
        d = '0;
        for (int c = 0; c < COLS; c++) begin
            acc = 0;
            for (int i = 0; i < k; i++) begin
                acc += longint'(a_mem[i][r]) * longint'(b_mem[i][c]);
            end
            v = int'(acc) >>> sh;
            if (relu && v < 0) v = 0;
            if (v > 127) v = 127;
            else if (v < -128) v = -128;
            d[c*8 +: 8] = 8'(v);
        end
        return d;
    endfunction

    task automatic push_model(input int k, input bit relu, input int sh);
        for (int r = 0; r < ROWS; r++) begin
            push0(r, model_row(r, k, relu, sh));
        end
    endtask

    // Command inputs are scrambled right after acceptance; the tile must ignore them.
    task automatic issue(input int k, input bit relu, input int sh);
        start     = 1'b1;
        dim_k     = 16'(k);
        relu_en   = relu;
        shift     = SHIFT_W'(sh);
        start_cyc = cyc;
        tick();
        start   = 1'b0;
        dim_k   = 16'd7;
        relu_en = ~relu;
        shift   = SHIFT_W'(sh + 3);
    endtask

    task automatic send_beats(input int first, input int last, input bit gaps);
        int guard;
        for (int i = first; i <= last; i++) begin
            if (gaps && $urandom_range(0, 1) == 1) begin
                s0.in_valid = 1'b0;
                s0.in_a     = $urandom();
                s0.in_b     = $urandom();
                tick();
            end
            s0.in_valid = 1'b1;
            for (int r = 0; r < ROWS; r++) s0.in_a[r*DATA_W +: DATA_W] = 8'(a_mem[i][r]);
            for (int c = 0; c < COLS; c++) s0.in_b[c*DATA_W +: DATA_W] = 8'(b_mem[i][c]);
            guard = 0;
            while (!s0.in_ready && guard < 50) begin
                tick();
                guard++;
            end
            if (!s0.in_ready) begin
                n_checks++;
                $display("FAIL beat_accept: in_ready stayed low for beat %0d", i);
            end
            tick();
        end
        s0.in_valid = 1'b0;
    endtask

    task automatic wait_done(input int hold_row, input int hold_n);
        int d0;
        int held;
        int guard;
        d0    = done_cnt;
        held  = 0;
        guard = 0;
        while (done_cnt == d0 && guard < 300) begin
            if (s0.out_valid && s0.out_row_idx == 2'(hold_row) && held < hold_n) begin
                s0.out_ready = 1'b0;
                held++;
            end else begin
                s0.out_ready = 1'b1;
            end
            tick();
            guard++;
        end
        s0.out_ready = 1'b1;
        tick();
        tick();
        check("done_once", 64'(done_cnt - d0), 64'(1));
        check("idle_after_done", 64'(busy0), 64'(0));
    endtask

    initial begin
        int d0;
        rst          = 1'b1;
        start        = 1'b0;
        dim_k        = '0;
        relu_en      = 1'b0;
        shift        = '0;
        s0.in_valid  = 1'b0;
        s0.in_a      = '0;
        s0.in_b      = '0;
        s0.out_ready = 1'b1;
        repeat (3) tick();
        rst = 1'b0;
        check("rst_busy", 64'(busy0), 64'(0));
        check("rst_done", 64'(done0), 64'(0));
        check("rst_in_ready", 64'(s0.in_ready), 64'(0));
        check("rst_out_valid", 64'(s0.out_valid), 64'(0));
        check("rst_row_idx", 64'(s0.out_row_idx), 64'(0));
        check("rst_out_data", 64'(s0.out_data), 64'(0));
        tick();

        // Identity A: outputs reproduce the B rows.
        for (int i = 0; i < 4; i++) begin
            for (int r = 0; r < ROWS; r++) a_mem[i][r] = (r == i) ? 1 : 0;
            for (int c = 0; c < COLS; c++) b_mem[i][c] = 4 * i + c + 1;
        end
        for (int r = 0; r < ROWS; r++) push0(r, {8'(4*r+4), 8'(4*r+3), 8'(4*r+2), 8'(4*r+1)});
        issue(4, 1'b0, 0);
        send_beats(0, 3, 1'b0);
        wait_done(0, 0);
        check("latency_k4", 64'(done_cyc - start_cyc + 1), 64'(10));

        // Requant, saturation, ReLU on a single beat of 127 x {127,-128,2,-2}.
        for (int r = 0; r < ROWS; r++) a_mem[0][r] = 127;
        b_mem[0][0] = 127; b_mem[0][1] = -128; b_mem[0][2] = 2; b_mem[0][3] = -2;
        rq_exp[0] = 32'h807F807F; rq_relu[0] = 1'b0; rq_sh[0] = 0;
        rq_exp[1] = 32'h007F007F; rq_relu[1] = 1'b1; rq_sh[1] = 0;
        rq_exp[2] = 32'hFF00C03F; rq_relu[2] = 1'b0; rq_sh[2] = 8;
        for (int t = 0; t < 3; t++) begin
            for (int r = 0; r < ROWS; r++) push0(r, rq_exp[t]);
            issue(1, rq_relu[t], rq_sh[t]);
            send_beats(0, 0, 1'b0);
            wait_done(0, 0);
        end

        // Input gaps and a five-cycle stall on row 2.
        for (int i = 0; i < 5; i++) begin
            for (int r = 0; r < ROWS; r++) a_mem[i][r] = 20 * i - 15 * r - 10;
            for (int c = 0; c < COLS; c++) b_mem[i][c] = 13 * c - 7 * i + 3;
        end
        push_model(5, 1'b0, 5);
        issue(5, 1'b0, 5);
        send_beats(0, 4, 1'b1);
        wait_done(2, 5);

        // Zero depth: drain straight away with all-zero rows.
        for (int r = 0; r < ROWS; r++) push0(r, 32'h0);
        issue(0, 1'b0, 0);
        check("k0_row0_valid", 64'(s0.out_valid), 64'(1));
        wait_done(0, 0);

        // A second start during ACCUM must not relatch dim_k.
        for (int i = 0; i < 2; i++) begin
            for (int r = 0; r < ROWS; r++) a_mem[i][r] = i + r + 1;
            for (int c = 0; c < COLS; c++) b_mem[i][c] = c - 2 * i;
        end
        push_model(2, 1'b0, 0);
        issue(2, 1'b0, 0);
        send_beats(0, 0, 1'b0);
        start = 1'b1;
        dim_k = 16'd5;
        tick();
        start = 1'b0;
        check("busy_held", 64'(busy0), 64'(1));
        check("still_accum", 64'(s0.in_ready), 64'(1));
        send_beats(1, 1, 1'b0);
        wait_done(0, 0);

        // Reset after two of four beats, then a fresh command on cleared accumulators.
        for (int i = 0; i < 4; i++) begin
            for (int r = 0; r < ROWS; r++) a_mem[i][r] = 10;
            for (int c = 0; c < COLS; c++) b_mem[i][c] = 10;
        end
        issue(4, 1'b0, 0);
        send_beats(0, 1, 1'b0);
        d0  = done_cnt;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("rst_mid_busy", 64'(busy0), 64'(0));
        check("rst_mid_in_ready", 64'(s0.in_ready), 64'(0));
        check("rst_mid_out_valid", 64'(s0.out_valid), 64'(0));
        repeat (3) tick();
        check("rst_mid_no_done", 64'(done_cnt - d0), 64'(0));
        for (int r = 0; r < ROWS; r++) a_mem[0][r] = 1;
        for (int c = 0; c < COLS; c++) b_mem[0][c] = c + 1;
        for (int r = 0; r < ROWS; r++) push0(r, 32'h04030201);
        issue(1, 1'b0, 0);
        send_beats(0, 0, 1'b0);
        wait_done(0, 0);

        // 3 x (-128*-128) = 49152: wraps to -16384 in a 16-bit accumulator.
        for (int i = 0; i < 3; i++) begin
            for (int r = 0; r < ROWS; r++) a_mem[i][r] = -128;
            for (int c = 0; c < COLS; c++) b_mem[i][c] = -128;
        end
        en16 = 1'b1;
        push_model(3, 1'b0, 8);
        for (int r = 0; r < ROWS; r++) push1(r, 32'hC0C0C0C0);
        issue(3, 1'b0, 8);
        send_beats(0, 2, 1'b0);
        wait_done(0, 0);
        en16 = 1'b0;

        repeat (2) tick();
        check("q0_drained", 64'(q0.size()), 64'(0));
        check("q1_drained", 64'(q1.size()), 64'(0));
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
